// File: rtl/l2_snoop_responder_pkg.sv
// Shared encodings for the L2 snoop responder: bus ops, snoop results,
// MESI states, L1 inclusivity messages and FSM states.
package l2_snoop_responder_pkg;

    typedef enum logic [1:0] {
        OP_READ       = 2'b00,
        OP_WRITE      = 2'b01,
        OP_RWIM       = 2'b10,
        OP_INVALIDATE = 2'b11
    } snoop_op_e;

    typedef enum logic [1:0] {
        RES_HIT   = 2'b00,
        RES_HITM  = 2'b01,
        RES_NOHIT = 2'b10
    } snoop_res_e;

    typedef enum logic [1:0] {
        MESI_I = 2'b00,
        MESI_S = 2'b01,
        MESI_E = 2'b10,
        MESI_M = 2'b11
    } mesi_e;

    typedef enum logic [1:0] {
        L1_NONE           = 2'b00,
        L1_GETLINE        = 2'b01,
        L1_INVALIDATELINE = 2'b10,
        L1_EVICTLINE      = 2'b11
    } l1_msg_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_CAPTURE,
        ST_RESP,
        ST_WB,
        ST_UPD
    } state_e;

    // A lookup miss behaves exactly like a hit on an Invalid line.
    function automatic mesi_e effective_mesi(input logic hit, input mesi_e mesi);
        return hit ? mesi : MESI_I;
    endfunction

endpackage

// File: rtl/l2_snoop_responder_mesi_decode.sv
// Combinational snoop decision: result, next MESI state, writeback need,
// L1 message and protocol error for one snooped op against one line state.
module l2_snoop_responder_mesi_decode
    import l2_snoop_responder_pkg::*;
(
    input  snoop_op_e  op,
    input  logic       hit,
    input  mesi_e      mesi,
    output snoop_res_e result,
    output mesi_e      next_mesi,
    output logic       need_wb,
    output l1_msg_e    l1_msg,
    output logic       l1_msg_valid,
    output logic       err
);

    mesi_e cur;

    always_comb begin
        cur          = effective_mesi(hit, mesi);
        result       = RES_NOHIT;
        next_mesi    = cur;
        need_wb      = 1'b0;
        l1_msg       = L1_NONE;
        l1_msg_valid = 1'b0;
        err          = 1'b0;
        case (op)
            OP_READ: begin
                case (cur)
                    MESI_M: begin
                        result       = RES_HITM;
                        l1_msg       = L1_GETLINE;
                        l1_msg_valid = 1'b1;
                        need_wb      = 1'b1;
                        next_mesi    = MESI_S;
                    end
                    MESI_E, MESI_S: begin
                        result    = RES_HIT;
                        next_mesi = MESI_S;
                    end
                    default: ;
                endcase
            end
            OP_RWIM: begin
                case (cur)
                    MESI_M: begin
                        result       = RES_HITM;
                        l1_msg       = L1_EVICTLINE;
                        l1_msg_valid = 1'b1;
                        need_wb      = 1'b1;
                        next_mesi    = MESI_I;
                    end
                    MESI_E, MESI_S: begin
                        result       = RES_HIT;
                        l1_msg       = L1_INVALIDATELINE;
                        l1_msg_valid = 1'b1;
                        next_mesi    = MESI_I;
                    end
                    default: ;
                endcase
            end
            // Another master writing a line we own exclusively means coherence broke.
            OP_WRITE: begin
                err = (cur == MESI_M) || (cur == MESI_E);
            end
            OP_INVALIDATE: begin
                case (cur)
                    MESI_S: begin
                        result       = RES_HIT;
                        l1_msg       = L1_INVALIDATELINE;
                        l1_msg_valid = 1'b1;
                        next_mesi    = MESI_I;
                    end
                    MESI_E, MESI_M: err = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/l2_snoop_responder.sv
// Bus-side snoop responder: looks up snooped lines, answers HIT/HITM/NOHIT,
// writes back Modified data, notifies L1 and applies the snoop MESI update.
module l2_snoop_responder
    import l2_snoop_responder_pkg::*;
#(
    parameter int INDEX_W  = 14,
    parameter int TAG_W    = 12,
    parameter int OFFSET_W = 6,
    parameter int WAY_W    = 3,
    parameter int CNT_W    = 16
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              snoop_valid,
    output logic                              snoop_ready,
    input  logic [1:0]                        snoop_op,
    input  logic [TAG_W+INDEX_W+OFFSET_W-1:0] snoop_addr,
    output logic                              lookup_req,
    output logic [INDEX_W-1:0]                lookup_index,
    output logic [TAG_W-1:0]                  lookup_tag,
    input  logic                              lookup_hit,
    input  logic [WAY_W-1:0]                  lookup_way,
    input  logic [1:0]                        lookup_mesi,
    output logic                              snoop_res_valid,
    output logic [1:0]                        snoop_res,
    output logic                              wb_req,
    output logic [TAG_W+INDEX_W+OFFSET_W-1:0] wb_addr,
    input  logic                              wb_ack,
    output logic                              upd_valid,
    output logic [INDEX_W-1:0]                upd_index,
    output logic [WAY_W-1:0]                  upd_way,
    output logic [1:0]                        upd_mesi,
    output logic                              l1_msg_valid,
    output logic [1:0]                        l1_msg,
    output logic                              protocol_err,
    output logic [CNT_W-1:0]                  hit_cnt,
    output logic [CNT_W-1:0]                  hitm_cnt
);

    localparam int ADDR_W = TAG_W + INDEX_W + OFFSET_W;

    state_e             state, state_next;
    logic               started;
    snoop_op_e          op_q;
    logic [TAG_W-1:0]   tag_q;
    logic [INDEX_W-1:0] index_q;
    logic               cap_hit;
    logic [WAY_W-1:0]   cap_way;
    mesi_e              cap_mesi;

    snoop_res_e dec_result;
    mesi_e      dec_next;
    logic       dec_wb;
    l1_msg_e    dec_msg;
    logic       dec_msg_valid;
    logic       dec_err;
    logic       change;
    logic       unused_offset;

    assign unused_offset = ^snoop_addr[OFFSET_W-1:0];

    l2_snoop_responder_mesi_decode u_decode (
        .op           (op_q),
        .hit          (cap_hit),
        .mesi         (cap_mesi),
        .result       (dec_result),
        .next_mesi    (dec_next),
        .need_wb      (dec_wb),
        .l1_msg       (dec_msg),
        .l1_msg_valid (dec_msg_valid),
        .err          (dec_err)
    );

    assign change = (dec_next != effective_mesi(cap_hit, cap_mesi));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next      = state;
        snoop_ready     = 1'b0;
        lookup_req      = 1'b0;
        snoop_res_valid = 1'b0;
        l1_msg_valid    = 1'b0;
        wb_req          = 1'b0;
        upd_valid       = 1'b0;
        case (state)
            ST_IDLE: begin
                snoop_ready = started;
                if (snoop_valid && started) state_next = ST_LOOKUP;
            end
            ST_LOOKUP: begin
                lookup_req = 1'b1;
                state_next = ST_CAPTURE;
            end
            ST_CAPTURE: state_next = ST_RESP;
            ST_RESP: begin
                snoop_res_valid = 1'b1;
                l1_msg_valid    = dec_msg_valid;
                if (dec_wb)      state_next = ST_WB;
                else if (change) state_next = ST_UPD;
                else             state_next = ST_IDLE;
            end
            ST_WB: begin
                wb_req = 1'b1;
                if (wb_ack) state_next = change ? ST_UPD : ST_IDLE;
            end
            ST_UPD: begin
                upd_valid  = 1'b1;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // started keeps snoop_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started      <= 1'b0;
            op_q         <= OP_READ;
            tag_q        <= '0;
            index_q      <= '0;
            cap_hit      <= 1'b0;
            cap_way      <= '0;
            cap_mesi     <= MESI_I;
            hit_cnt      <= '0;
            hitm_cnt     <= '0;
            protocol_err <= 1'b0;
        end else begin
            started <= 1'b1;
            if (snoop_valid && snoop_ready) begin
                op_q    <= snoop_op_e'(snoop_op);
                tag_q   <= snoop_addr[ADDR_W-1 -: TAG_W];
                index_q <= snoop_addr[OFFSET_W +: INDEX_W];
            end
            if (state == ST_CAPTURE) begin
                cap_hit  <= lookup_hit;
                cap_way  <= lookup_way;
                cap_mesi <= mesi_e'(lookup_mesi);
            end
            if (state == ST_RESP) begin
                if (dec_result == RES_HIT && hit_cnt != '1)
                    hit_cnt <= hit_cnt + CNT_W'(1);
                if (dec_result == RES_HITM && hitm_cnt != '1)
                    hitm_cnt <= hitm_cnt + CNT_W'(1);
                if (dec_err)
                    protocol_err <= 1'b1;
            end
        end
    end

    assign lookup_index = index_q;
    assign lookup_tag   = tag_q;
    assign wb_addr      = {tag_q, index_q, {OFFSET_W{1'b0}}};
    assign upd_index    = index_q;
    assign upd_way      = cap_way;
    assign upd_mesi     = upd_valid ? dec_next : 2'b00;
    assign snoop_res    = snoop_res_valid ? dec_result : 2'b00;
    assign l1_msg       = l1_msg_valid ? dec_msg : 2'b00;

endmodule

// File: tb/tb_l2_snoop_responder.sv
// Self-checking bench for l2_snoop_responder: directed scenarios plus random
// snoops checked against a rule-level MESI snoop model.
module tb_l2_snoop_responder;

    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [1:0] res;
        logic [1:0] next;
        logic       wb;
        logic [1:0] msg;
        logic       err;
        logic       upd;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              snoop_valid;
    logic              snoop_ready;
    logic [1:0]        snoop_op;
    logic [31:0]       snoop_addr;
    logic              lookup_req;
    logic [13:0]       lookup_index;
    logic [11:0]       lookup_tag;
    logic              lookup_hit;
    logic [2:0]        lookup_way;
    logic [1:0]        lookup_mesi;
    logic              snoop_res_valid;
    logic [1:0]        snoop_res;
    logic              wb_req;
    logic [31:0]       wb_addr;
    logic              wb_ack;
    logic              upd_valid;
    logic [13:0]       upd_index;
    logic [2:0]        upd_way;
    logic [1:0]        upd_mesi;
    logic              l1_msg_valid;
    logic [1:0]        l1_msg;
    logic              protocol_err;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  hitm_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int m_hit       = 0;
    int m_hitm      = 0;
    int m_err       = 0;

    l2_snoop_responder #(.CNT_W(CNT_W)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .snoop_valid     (snoop_valid),
        .snoop_ready     (snoop_ready),
        .snoop_op        (snoop_op),
        .snoop_addr      (snoop_addr),
        .lookup_req      (lookup_req),
        .lookup_index    (lookup_index),
        .lookup_tag      (lookup_tag),
        .lookup_hit      (lookup_hit),
        .lookup_way      (lookup_way),
        .lookup_mesi     (lookup_mesi),
        .snoop_res_valid (snoop_res_valid),
        .snoop_res       (snoop_res),
        .wb_req          (wb_req),
        .wb_addr         (wb_addr),
        .wb_ack          (wb_ack),
        .upd_valid       (upd_valid),
        .upd_index       (upd_index),
        .upd_way         (upd_way),
        .upd_mesi        (upd_mesi),
        .l1_msg_valid    (l1_msg_valid),
        .l1_msg          (l1_msg),
        .protocol_err    (protocol_err),
        .hit_cnt         (hit_cnt),
        .hitm_cnt        (hitm_cnt)
    );

    always #5 clk = ~clk;

    // Rules of the snoop protocol phrased in terms of line ownership.
    function automatic exp_t refModel(input logic [1:0] op, input logic hit, input logic [1:0] mesi);
        exp_t e;
        logic [1:0] line;
        bit present, dirty, exclusive;
        line      = hit ? mesi : 2'b00;
        present   = (line != 2'b00);
        dirty     = (line == 2'b11);
        exclusive = (line == 2'b10) || dirty;
        e      = '0;
        e.res  = 2'b10;
        e.next = line;
        if (op == 2'b00 && present) begin
            e.res  = dirty ? 2'b01 : 2'b00;
            e.next = 2'b01;
            e.wb   = dirty;
            e.msg  = dirty ? 2'b01 : 2'b00;
        end else if (op == 2'b10 && present) begin
            e.res  = dirty ? 2'b01 : 2'b00;
            e.next = 2'b00;
            e.wb   = dirty;
            e.msg  = dirty ? 2'b11 : 2'b10;
        end else if (op == 2'b01) begin
            e.err = exclusive;
        end else if (op == 2'b11) begin
            e.err = exclusive;
            if (line == 2'b01) begin
                e.res  = 2'b00;
                e.next = 2'b00;
                e.msg  = 2'b10;
            end
        end
        e.upd = (e.next != line);
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drives one snoop from an IDLE negedge and checks every phase of it.
    task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic hit,
                                 input logic [2:0] way, input logic [1:0] mesi,
                                 input int wbDelay, input bit abortInWb);
        exp_t e;
        e = refModel(op, hit, mesi);
        if (e.res == 2'b00 && m_hit < CNT_MAX) m_hit++;
        if (e.res == 2'b01 && m_hitm < CNT_MAX) m_hitm++;
        if (e.err) m_err = 1;

        checkOutput("ready_idle", 32'(snoop_ready), 1);
        snoop_valid = 1'b1;
        snoop_op    = op;
        snoop_addr  = addr;
        @(negedge clk);
        snoop_valid = 1'b0;
        snoop_op    = 2'($urandom);
        snoop_addr  = $urandom;
        checkOutput("lookup_req", 32'(lookup_req), 1);
        checkOutput("lookup_index", 32'(lookup_index), 32'(addr[19:6]));
        checkOutput("lookup_tag", 32'(lookup_tag), 32'(addr[31:20]));
        checkOutput("ready_busy", 32'(snoop_ready), 0);
        lookup_hit  = 1'($urandom);
        lookup_way  = 3'($urandom);
        lookup_mesi = 2'($urandom);
        @(negedge clk);
        checkOutput("lookup_req_low", 32'(lookup_req), 0);
        lookup_hit  = hit;
        lookup_way  = way;
        lookup_mesi = mesi;
        @(negedge clk);
        lookup_hit  = 1'($urandom);
        lookup_way  = 3'($urandom);
        lookup_mesi = 2'($urandom);
        wb_ack      = 1'($urandom);
        checkOutput("res_valid", 32'(snoop_res_valid), 1);
        checkOutput("snoop_res", 32'(snoop_res), 32'(e.res));
        checkOutput("l1_msg_valid", 32'(l1_msg_valid), 32'(e.msg != 2'b00));
        if (e.msg != 2'b00) checkOutput("l1_msg", 32'(l1_msg), 32'(e.msg));
        checkOutput("wb_req_resp", 32'(wb_req), 0);
        @(negedge clk);
        wb_ack = 1'b0;
        if (e.wb) begin
            for (int d = 0; d <= wbDelay; d++) begin
                checkOutput("wb_req", 32'(wb_req), 1);
                checkOutput("wb_addr", wb_addr, {addr[31:6], 6'b0});
                checkOutput("upd_in_wb", 32'(upd_valid), 0);
                if (abortInWb && d == 2) begin
                    rst_n = 1'b0;
                    #1;
                    m_hit = 0; m_hitm = 0; m_err = 0;
                    checkOutput("abort_wb_req", 32'(wb_req), 0);
                    checkOutput("abort_upd", 32'(upd_valid), 0);
                    checkOutput("abort_ready", 32'(snoop_ready), 0);
                    checkOutput("abort_hitm_cnt", 32'(hitm_cnt), 0);
                    @(negedge clk);
                    rst_n = 1'b1;
                    @(negedge clk);
                    return;
                end
                wb_ack = (d == wbDelay) && !abortInWb;
                @(negedge clk);
                wb_ack = 1'b0;
            end
        end
        if (e.upd) begin
            checkOutput("upd_valid", 32'(upd_valid), 1);
            checkOutput("upd_index", 32'(upd_index), 32'(addr[19:6]));
            checkOutput("upd_way", 32'(upd_way), 32'(way));
            checkOutput("upd_mesi", 32'(upd_mesi), 32'(e.next));
            @(negedge clk);
        end
        checkOutput("no_upd", 32'(upd_valid), 0);
        checkOutput("wb_req_done", 32'(wb_req), 0);
        checkOutput("hit_cnt", 32'(hit_cnt), 32'(m_hit));
        checkOutput("hitm_cnt", 32'(hitm_cnt), 32'(m_hitm));
        checkOutput("protocol_err", 32'(protocol_err), 32'(m_err));
    endtask

    initial begin
        rst_n       = 1'b0;
        snoop_valid = 1'b0;
        snoop_op    = 2'b00;
        snoop_addr  = '0;
        lookup_hit  = 1'b0;
        lookup_way  = '0;
        lookup_mesi = '0;
        wb_ack      = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(snoop_ready), 0);
        checkOutput("rst_lookup_req", 32'(lookup_req), 0);
        checkOutput("rst_res_valid", 32'(snoop_res_valid), 0);
        checkOutput("rst_snoop_res", 32'(snoop_res), 0);
        checkOutput("rst_wb_req", 32'(wb_req), 0);
        checkOutput("rst_wb_addr", wb_addr, 0);
        checkOutput("rst_upd_valid", 32'(upd_valid), 0);
        checkOutput("rst_l1_valid", 32'(l1_msg_valid), 0);
        checkOutput("rst_hit_cnt", 32'(hit_cnt), 0);
        checkOutput("rst_hitm_cnt", 32'(hitm_cnt), 0);
        checkOutput("rst_err", 32'(protocol_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] directed scenarios");
        applyStimulus(2'b00, 32'hA5C3_F17B, 1'b1, 3'd2, 2'b11, 3, 1'b0);
        applyStimulus(2'b10, 32'h1234_5678, 1'b1, 3'd5, 2'b10, 0, 1'b0);
        applyStimulus(2'b00, 32'h0BAD_CAFE, 1'b1, 3'd1, 2'b01, 0, 1'b0);
        applyStimulus(2'b00, 32'h7777_0000, 1'b0, 3'd3, 2'b11, 0, 1'b0);
        applyStimulus(2'b11, 32'hDEAD_BEEF, 1'b1, 3'd4, 2'b11, 0, 1'b0);
        applyStimulus(2'b01, 32'hFACE_0042, 1'b0, 3'd0, 2'b10, 0, 1'b0);
        applyStimulus(2'b00, 32'h0F0F_0F0F, 1'b0, 3'd6, 2'b00, 0, 1'b0);
        applyStimulus(2'b00, 32'hC0DE_1234, 1'b1, 3'd7, 2'b11, 20, 1'b1);
        applyStimulus(2'b00, 32'h5555_AAAA, 1'b0, 3'd2, 2'b00, 0, 1'b0);

        $display("[TB] random snoops");
        for (int i = 0; i < 60; i++) begin
            applyStimulus(2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
                          int'($urandom_range(0, 3)), 1'b0);
        end

        $display("[TB] hit counter saturation");
        for (int i = 0; i <= CNT_MAX; i++) begin
            applyStimulus(2'b00, $urandom, 1'b1, 3'($urandom_range(0, 7)), 2'b01, 0, 1'b0);
        end
        checkOutput("hit_cnt_saturated", 32'(hit_cnt), 32'(CNT_MAX));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
